// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with a pending-write
// scoreboard. Decode reads operands and marks destinations busy at issue;
// writeback stores results and clears busy. Reads are combinational with a
// write-through bypass from the writeback port, so a result arriving in the
// same cycle as a dependent read both supplies the data and clears the hazard.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset (clears data and busy bits)
//   rd_addr_i    NRD read addresses, port k at [k*AW +: AW]
//   rd_data_o    NRD read data words, port k at [k*XLEN +: XLEN]
//   rd_busy_o    per read port: addressed register has an outstanding producer
//   iss_valid_i  mark iss_rd_i pending this cycle
//   iss_rd_i     destination register being issued
//   wb_valid_i   writeback strobe
//   wb_rd_i      writeback destination
//   wb_data_i    writeback value
//   busy_vec_o   registered busy bit per register
//   any_busy_o   OR of rd_busy_o (stall request)
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                iss_valid_i,
    input  logic [AW-1:0]       iss_rd_i,
    input  logic                wb_valid_i,
    input  logic [AW-1:0]       wb_rd_i,
    input  logic [XLEN-1:0]     wb_data_i,
    output logic [NREGS-1:0]    busy_vec_o,
    output logic                any_busy_o
);

    // Out-of-range addresses and the hardwired zero register are neither
    // writable nor readable (they read as 0, never busy), so one predicate
    // serves both the read and the write side.
    function automatic logic writable(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wb_en;
    logic             iss_en;
    logic [AW-1:0]    rd_a;

    // wb_en already excludes reset, so it doubles as the bypass qualifier.
    assign wb_en  = !rst_i && wb_valid_i && writable(wb_rd_i);
    assign iss_en = iss_valid_i && writable(iss_rd_i);

    // Writeback clears first so that a same-cycle issue to the same
    // register wins: the newer producer is still outstanding.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (wb_en && (wb_rd_i == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
            if (iss_en && (iss_rd_i == AW'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else if (wb_en) begin
            for (int r = 0; r < NREGS; r++) begin
                if (wb_rd_i == AW'(r)) begin
                    mem_q[r] <= wb_data_i;
                end
            end
        end
    end

    // A bypass hit resolves the hazard in the same cycle, so it masks busy.
    // A same-cycle issue is deliberately not visible until busy_q updates.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        rd_a      = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_a = rd_addr_i[k*AW +: AW];
            if (writable(rd_a)) begin
                if (wb_en && (wb_rd_i == rd_a)) begin
                    rd_data_o[k*XLEN +: XLEN] = wb_data_i;
                    rd_busy_o[k]              = 1'b0;
                end else begin
                    rd_data_o[k*XLEN +: XLEN] = mem_q[rd_a];
                    rd_busy_o[k]              = busy_q[rd_a];
                end
            end
        end
    end

    assign busy_vec_o = busy_q;
    assign any_busy_o = |rd_busy_o;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // DUT 0: defaults (XLEN 32, 32 regs, 2 ports, zero reg)
    logic        a_rst, a_iv, a_wv, a_any;
    logic [4:0]  a_ird, a_wrd;
    logic [31:0] a_wd, a_bvec;
    logic [9:0]  a_addr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rbusy;

    // DUT 1: XLEN 64, 16 regs, 3 ports, no zero reg
    logic         b_rst, b_iv, b_wv, b_any;
    logic [3:0]   b_ird, b_wrd;
    logic [63:0]  b_wd;
    logic [15:0]  b_bvec;
    logic [11:0]  b_addr;
    logic [191:0] b_rdata;
    logic [2:0]   b_rbusy;

    // DUT 2: XLEN 16, 20 regs (non power of two), 2 ports, zero reg
    logic        c_rst, c_iv, c_wv, c_any;
    logic [4:0]  c_ird, c_wrd;
    logic [15:0] c_wd;
    logic [19:0] c_bvec;
    logic [9:0]  c_addr;
    logic [31:0] c_rdata;
    logic [1:0]  c_rbusy;

    regfile_sb u_dut_a (
        .clk_i(clk), .rst_i(a_rst), .rd_addr_i(a_addr), .rd_data_o(a_rdata),
        .rd_busy_o(a_rbusy), .iss_valid_i(a_iv), .iss_rd_i(a_ird),
        .wb_valid_i(a_wv), .wb_rd_i(a_wrd), .wb_data_i(a_wd),
        .busy_vec_o(a_bvec), .any_busy_o(a_any)
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0)) u_dut_b (
        .clk_i(clk), .rst_i(b_rst), .rd_addr_i(b_addr), .rd_data_o(b_rdata),
        .rd_busy_o(b_rbusy), .iss_valid_i(b_iv), .iss_rd_i(b_ird),
        .wb_valid_i(b_wv), .wb_rd_i(b_wrd), .wb_data_i(b_wd),
        .busy_vec_o(b_bvec), .any_busy_o(b_any)
    );

    regfile_sb #(.XLEN(16), .NREGS(20), .NRD(2), .ZERO_REG(1)) u_dut_c (
        .clk_i(clk), .rst_i(c_rst), .rd_addr_i(c_addr), .rd_data_o(c_rdata),
        .rd_busy_o(c_rbusy), .iss_valid_i(c_iv), .iss_rd_i(c_ird),
        .wb_valid_i(c_wv), .wb_rd_i(c_wrd), .wb_data_i(c_wd),
        .busy_vec_o(c_bvec), .any_busy_o(c_any)
    );

    // Reference model: one array of register values and busy flags per DUT.
    logic [63:0] m_mem  [3][64];
    bit          m_busy [3][64];
    int m_n    [3] = '{32, 16, 20};
    int m_z    [3] = '{1, 0, 1};
    int m_xlen [3] = '{32, 64, 16};
    int m_nrd  [3] = '{2, 3, 2};
    int m_aw   [3] = '{5, 4, 5};

    int          cur_d;
    bit          cur_rst, cur_iv, cur_wv;
    int          cur_ird, cur_wrd;
    logic [63:0] cur_wd;
    int          cur_a [3];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_wr(input int d, input int a);
        return (a >= 0) && (a < m_n[d]) && !((m_z[d] != 0) && (a == 0));
    endfunction

    function automatic bit m_hit(input int d, input int a);
        return !cur_rst && cur_wv && (cur_wrd == a) && m_wr(d, a);
    endfunction

    function automatic logic [63:0] m_data(input int d, input int a);
        if (!m_wr(d, a)) return 64'd0;
        if (m_hit(d, a)) return cur_wd;
        return m_mem[d][a];
    endfunction

    function automatic bit m_rbusy(input int d, input int a);
        if (!m_wr(d, a) || m_hit(d, a)) return 1'b0;
        return m_busy[d][a];
    endfunction

    function automatic void m_step();
        if (cur_rst) begin
            for (int r = 0; r < 64; r++) begin
                m_mem[cur_d][r]  = 64'd0;
                m_busy[cur_d][r] = 1'b0;
            end
        end else begin
            if (cur_wv && m_wr(cur_d, cur_wrd)) begin
                m_mem[cur_d][cur_wrd]  = cur_wd;
                m_busy[cur_d][cur_wrd] = 1'b0;
            end
            if (cur_iv && m_wr(cur_d, cur_ird)) begin
                m_busy[cur_d][cur_ird] = 1'b1;
            end
        end
    endfunction

    function automatic logic [63:0] obs_data(input int d, input int k);
        case (d)
            0:       return 64'(a_rdata[k*32 +: 32]);
            1:       return b_rdata[k*64 +: 64];
            default: return 64'(c_rdata[k*16 +: 16]);
        endcase
    endfunction

    function automatic logic obs_busy(input int d, input int k);
        case (d)
            0:       return a_rbusy[k];
            1:       return b_rbusy[k];
            default: return c_rbusy[k];
        endcase
    endfunction

    function automatic logic obs_any(input int d);
        case (d)
            0:       return a_any;
            1:       return b_any;
            default: return c_any;
        endcase
    endfunction

    function automatic logic [63:0] obs_bvec(input int d);
        case (d)
            0:       return 64'(a_bvec);
            1:       return 64'(b_bvec);
            default: return 64'(c_bvec);
        endcase
    endfunction

    // Drive one cycle's inputs on the falling edge, then check the
    // combinational read side against the model before the rising edge.
    task automatic drive_cycle(input int d, input bit r, input bit iv, input int ird,
                               input bit wv, input int wrd, input logic [63:0] wd,
                               input int a0, input int a1, input int a2);
        logic [63:0] mask;
        bit          any_e;
        mask = (m_xlen[d] == 64) ? '1 : ((64'd1 << m_xlen[d]) - 64'd1);
        @(negedge clk);
        cur_d = d; cur_rst = r; cur_iv = iv; cur_ird = ird;
        cur_wv = wv; cur_wrd = wrd; cur_wd = wd & mask;
        cur_a[0] = a0; cur_a[1] = a1; cur_a[2] = a2;
        case (d)
            0: begin
                a_rst = r; a_iv = iv; a_ird = 5'(ird); a_wv = wv; a_wrd = 5'(wrd);
                a_wd = cur_wd[31:0]; a_addr = {5'(a1), 5'(a0)};
            end
            1: begin
                b_rst = r; b_iv = iv; b_ird = 4'(ird); b_wv = wv; b_wrd = 4'(wrd);
                b_wd = cur_wd; b_addr = {4'(a2), 4'(a1), 4'(a0)};
            end
            default: begin
                c_rst = r; c_iv = iv; c_ird = 5'(ird); c_wv = wv; c_wrd = 5'(wrd);
                c_wd = cur_wd[15:0]; c_addr = {5'(a1), 5'(a0)};
            end
        endcase
        #1;
        any_e = 1'b0;
        for (int k = 0; k < m_nrd[d]; k++) begin
            check_val($sformatf("d%0d_rd_data%0d_a%0d", d, k, cur_a[k]),
                      obs_data(d, k), m_data(d, cur_a[k]));
            check_val($sformatf("d%0d_rd_busy%0d_a%0d", d, k, cur_a[k]),
                      64'(obs_busy(d, k)), 64'(m_rbusy(d, cur_a[k])));
            any_e |= m_rbusy(d, cur_a[k]);
        end
        check_val($sformatf("d%0d_any_busy", d), 64'(obs_any(d)), 64'(any_e));
    endtask

    task automatic finish_cycle();
        logic [63:0] exp_v;
        @(posedge clk);
        #1;
        m_step();
        case (cur_d)
            0:       begin a_rst = 1'b0; a_iv = 1'b0; a_wv = 1'b0; end
            1:       begin b_rst = 1'b0; b_iv = 1'b0; b_wv = 1'b0; end
            default: begin c_rst = 1'b0; c_iv = 1'b0; c_wv = 1'b0; end
        endcase
        exp_v = 64'd0;
        for (int r = 0; r < m_n[cur_d]; r++) exp_v[r] = m_busy[cur_d][r];
        check_val($sformatf("d%0d_busy_vec", cur_d), obs_bvec(cur_d), exp_v);
    endtask

    task automatic run_cycle(input int d, input bit r, input bit iv, input int ird,
                             input bit wv, input int wrd, input logic [63:0] wd,
                             input int a0, input int a1, input int a2);
        drive_cycle(d, r, iv, ird, wv, wrd, wd, a0, a1, a2);
        finish_cycle();
    endtask

    function automatic int rnd_addr(input int d);
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, (1 << m_aw[d]) - 1));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        a_rst = 1'b1; a_iv = 1'b0; a_wv = 1'b0; a_ird = '0; a_wrd = '0; a_wd = '0; a_addr = '0;
        b_rst = 1'b1; b_iv = 1'b0; b_wv = 1'b0; b_ird = '0; b_wrd = '0; b_wd = '0; b_addr = '0;
        c_rst = 1'b1; c_iv = 1'b0; c_wv = 1'b0; c_ird = '0; c_wrd = '0; c_wd = '0; c_addr = '0;
        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < 64; r++) begin
                m_mem[d][r]  = 64'd0;
                m_busy[d][r] = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        // State straight after reset
        for (int d = 0; d < 3; d++) begin
            drive_cycle(d, 0, 0, 0, 0, 0, 64'd0, 0, 1, 15);
            check_val($sformatf("d%0d_rst_bvec", d), obs_bvec(d), 64'd0);
            check_val($sformatf("d%0d_rst_data1", d), obs_data(d, 1), 64'd0);
            finish_cycle();
        end

        // Reset clears a written register
        run_cycle(0, 0, 0, 0, 1, 5, 64'hDEADBEEF, 5, 5, 0);
        run_cycle(0, 0, 1, 6, 0, 0, 64'd0, 5, 6, 0);
        run_cycle(0, 1, 0, 0, 0, 0, 64'd0, 5, 6, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 64'd0, 5, 6, 0);
        check_val("rst_clear_r5", obs_data(0, 0), 64'd0);
        check_val("rst_clear_bvec", obs_bvec(0), 64'd0);
        finish_cycle();

        // Write-through bypass
        drive_cycle(0, 0, 0, 0, 1, 7, 64'h12345678, 0, 7, 0);
        check_val("bypass_p1", obs_data(0, 1), 64'h12345678);
        finish_cycle();
        drive_cycle(0, 0, 0, 0, 0, 0, 64'd0, 7, 0, 0);
        check_val("bypass_stored", obs_data(0, 0), 64'h12345678);
        finish_cycle();

        // Scoreboard lifecycle on r3
        run_cycle(0, 0, 1, 3, 0, 0, 64'd0, 0, 3, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 64'd0, 0, 3, 0);
        check_val("sb_rd_busy_c1", 64'(obs_busy(0, 1)), 64'd1);
        check_val("sb_any_busy_c1", 64'(obs_any(0)), 64'd1);
        v = obs_bvec(0);
        check_val("sb_bvec3_c1", 64'(v[3]), 64'd1);
        finish_cycle();
        run_cycle(0, 0, 0, 0, 0, 0, 64'd0, 3, 0, 0);
        drive_cycle(0, 0, 0, 0, 1, 3, 64'hA5, 0, 3, 0);
        check_val("sb_rd_busy_c3", 64'(obs_busy(0, 1)), 64'd0);
        check_val("sb_rd_data_c3", obs_data(0, 1), 64'hA5);
        finish_cycle();
        v = obs_bvec(0);
        check_val("sb_bvec3_c4", 64'(v[3]), 64'd0);

        // Simultaneous issue and writeback on r9
        run_cycle(0, 0, 1, 9, 1, 9, 64'h55, 9, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 64'd0, 9, 9, 0);
        check_val("isswb_r9_data", obs_data(0, 0), 64'h55);
        check_val("isswb_r9_rdbusy", 64'(obs_busy(0, 1)), 64'd1);
        v = obs_bvec(0);
        check_val("isswb_bvec9", 64'(v[9]), 64'd1);
        finish_cycle();

        // Zero register ignores issue and writeback
        drive_cycle(0, 0, 1, 0, 1, 0, 64'hFFFFFFFF, 0, 0, 0);
        check_val("zero_data", obs_data(0, 0), 64'd0);
        check_val("zero_busy", 64'(obs_busy(0, 1)), 64'd0);
        finish_cycle();
        v = obs_bvec(0);
        check_val("zero_bvec0", 64'(v[0]), 64'd0);

        // Wide, three-port, no zero register
        run_cycle(1, 0, 0, 0, 1, 0, 64'h1, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 64'd0, 0, 0, 0);
        for (int k = 0; k < 3; k++) check_val($sformatf("b_r0_p%0d", k), obs_data(1, k), 64'h1);
        finish_cycle();
        run_cycle(1, 0, 1, 2, 0, 0, 64'd0, 2, 4, 0);
        run_cycle(1, 0, 0, 0, 1, 4, 64'hCAFEF00D_12345678, 2, 4, 0);
        run_cycle(1, 1, 1, 2, 1, 4, 64'h1111_2222_3333_4444, 4, 2, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 64'd0, 4, 2, 0);
        check_val("b_midrst_bvec", obs_bvec(1), 64'd0);
        check_val("b_midrst_r4", obs_data(1, 0), 64'd0);
        finish_cycle();

        // Out-of-range and top register on the 20-entry file
        run_cycle(2, 0, 1, 25, 1, 25, 64'hBEEF, 25, 19, 0);
        run_cycle(2, 0, 1, 19, 1, 19, 64'hABCD, 19, 25, 0);
        drive_cycle(2, 0, 0, 0, 0, 0, 64'd0, 25, 19, 0);
        check_val("c_oor_data", obs_data(2, 0), 64'd0);
        check_val("c_oor_busy", 64'(obs_busy(2, 0)), 64'd0);
        check_val("c_r19_data", obs_data(2, 1), 64'hABCD);
        check_val("c_r19_busy", 64'(obs_busy(2, 1)), 64'd1);
        finish_cycle();

        // Randomised traffic on all three configurations
        for (int i = 0; i < 900; i++) begin
            int d;
            d = i % 3;
            run_cycle(d, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, rnd_addr(d),
                      $urandom_range(0, 1) == 1, rnd_addr(d), {$urandom, $urandom},
                      rnd_addr(d), rnd_addr(d), rnd_addr(d));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file with an integrated pending-write scoreboard for the pipelined core.
- Generalises the current 2-read/1-write file in data width, register count and read-port count.
- Adds synchronous clear and per-register busy tracking, set at issue and cleared at writeback.
- Sits between decode (reads, issue marking) and writeback; rd_busy feeds the hazard/stall unit.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (2..64; need not be a power of 2)
NRD, 2, number of read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy
(localparam AW = clog2(NREGS))

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
rd_addr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
rd_data  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
rd_busy  out  NRD  port k's register has an outstanding producer
iss_valid  in  1  mark iss_rd pending this cycle
iss_rd  in  AW  destination register being issued
wb_valid  in  1  writeback strobe
wb_rd  in  AW  writeback destination
wb_data  in  XLEN  writeback value
busy_vec  out  NREGS  registered busy bit per register
any_busy  out  1  OR of rd_busy (stall request)

Behaviour:
- Writable address: a < NREGS, and not (ZERO_REG=1 and a=0).
- Out-of-range addresses (a >= NREGS):
  - reads return 0 with rd_busy=0;
  - iss/wb to them are ignored.
- Reset (rst=1 at an edge):
  - all registers cleared to 0; all busy bits cleared;
  - rst overrides iss_valid/wb_valid in the same cycle;
  - busy_vec=0 from the following cycle.
- Reads: combinational, zero latency, independent per port.
- Write-through bypass: if rst=0, wb_valid=1, wb_rd==rd_addr[k] and the address is writable, rd_data[k]=wb_data; otherwise array content.
- Bypass is suppressed while rst=1; reads then return current array contents.
- Write: at the edge with rst=0, wb_valid=1 and wb_rd writable, reg[wb_rd] <= wb_data.
- Busy update at the edge (rst=0), per writable register r:
  - set if iss_valid and iss_rd==r;
  - else clear if wb_valid and wb_rd==r;
  - else hold.
  - Issue and writeback to the same r in the same cycle: data written, busy stays 1 (the newer producer wins).
  - Issue to an already-busy register: stays busy; no counting, single outstanding producer assumed.
  - Writeback to a non-busy register: data written, busy stays 0; not an error.
- Read-side busy: rd_busy[k] = busy[rd_addr[k]] AND NOT (this-cycle bypass hit on port k).
  - Same-cycle writeback resolves the hazard.
  - Same-cycle issue does NOT raise rd_busy; it is visible next cycle.
- ZERO_REG=1:
  - address 0 always reads 0 with rd_busy=0;
  - iss/wb to register 0 are ignored, including bypass.
- ZERO_REG=0: register 0 behaves like any other register.
- any_busy = OR of rd_busy[NRD-1:0].
- Outputs after reset:
  - rd_data = 0 for all addresses;
  - rd_busy = 0, busy_vec = 0, any_busy = 0.
- Multiple read ports addressing the same register return identical data and busy.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5 via wb, pulse rst one cycle -> r5 reads 0x00000000, busy_vec=0.
- Bypass: wb_valid=1, wb_rd=7, wb_data=0x12345678, rd_addr port1=7 in the same cycle -> rd_data[1]=0x12345678 combinationally; the array holds it after the edge.
- Scoreboard lifecycle: iss r3 at cycle 0 -> busy_vec[3]=1 and rd_busy=1 for a port reading r3 at cycle 1; wb r3=0xA5 at cycle 3 -> rd_busy=0 that same cycle with data 0xA5, busy_vec[3]=0 at cycle 4.
- Simultaneous iss+wb on r9 (wb_data=0x55) -> reg9=0x55, busy_vec[9]=1 afterwards.
- Zero register (ZERO_REG=1): iss r0 and wb r0=0xFFFFFFFF -> r0 reads 0, rd_busy=0, busy_vec[0]=0.
- Param sweep NREGS=16, NRD=3, XLEN=64, ZERO_REG=0:
  - wb r0=0x1 reads back 0x1 on all three ports;
  - reset mid-operation (rst with iss r2 and wb r4 asserted) -> busy_vec=0, r4=0.
